uart_xmit: RTL and testbench
============================

// Module: uart_xmit
// PURPOSE
//  Serial UART transmitter, the line-side peer of uart_rcv. It accepts a byte
//  from the CPU bus on a one-cycle WR strobe and serialises it on TxD.
//  Frame: start(0), D[7:0] LSB first, even parity, stop(1).
//  Each bit lasts CLKS_PER_BIT clocks, matching the receiver's 16x sampling.
//  In loopback, TxD drives uart_rcv.RxD directly.
// PARAMETERS
//  CLKS_PER_BIT  16  Clock cycles each serial bit is held on TxD.
//  FIFO_DEPTH    4   Transmit FIFO entries (power of 2); used only with UART_XMIT_FIFO_EN.
// PORTS
//  Clock   in   1   System clock; all state changes on rising edge.
//  Reset   in   1   Synchronous, active-high reset.
//  Din     in   32  Write data; only Din[7:0] transmitted, [31:8] ignored.
//  WR      in   1   Write strobe; accepted on a rising edge where TxRDY=1.
//  TxD     out  1   Serial line; idles high.
//  TxRDY   out  1   1 = a WR this cycle will be accepted.
//  TxBusy  out  1   1 = a frame is on the line (start bit through stop bit).
// BEHAVIOUR
//  Reset (sync, dominant over WR): TxD=1, TxRDY=1, TxBusy=0, state=IDLE,
//   bit/clock counters=0, shift register=0, FIFO empty.
//  Reset mid-frame: the frame is aborted. TxD=1 from the next edge; no partial
//   bits are resumed.
//  FSM: IDLE -> START -> DATA(8 bits) -> PARITY -> STOP -> IDLE (or START, FIFO mode).
//  Clock counter runs 0..CLKS_PER_BIT-1 per bit; it advances to the next bit on
//   terminal count.
//  Accepted WR at edge N: Din[7:0] latched, parity = ^Din[7:0] latched.
//   TxD=0 (start bit) from edge N+1. Latency is 1 clock.
//  Bit order on TxD: start, D0..D7, P, stop. Frame = 11*CLKS_PER_BIT clocks (176).
//  TxBusy is 1 for exactly 11*CLKS_PER_BIT clocks per frame.
//  Non-FIFO mode: TxRDY = (state==IDLE). TxRDY drops at edge N+1 and returns to 1
//   at the edge that ends the stop bit.
//  WR while TxRDY=0 is ignored silently. The in-flight frame and data are unchanged.
//  WR asserted for multiple cycles: one byte taken (the first accepted edge only).
//  TxD is registered (no glitches). It changes only on bit boundaries.
// CONFIGURATION
//  UART_XMIT_FIFO_EN defined:
//   - A FIFO_DEPTH-entry FIFO sits before the serialiser. TxRDY = !full (registered).
//   - Accepted WR pushes to the FIFO. The serialiser pops when IDLE, or at the end of
//     STOP if the FIFO is non-empty, so queued frames go out back-to-back with no idle gap.
//   - Push and pop in the same cycle are both honoured; occupancy is unchanged.
//   - WR when full is dropped. Pointers wrap modulo FIFO_DEPTH.
//   - Reset empties the FIFO.
//  UART_XMIT_FIFO_EN undefined: no FIFO; single-byte behaviour as above.
// TESTING
//  1. Reset held 2 clocks -> TxD=1, TxRDY=1, TxBusy=0. With WR=0 for 100 clocks, TxD stays 1.
//  2. WR Din=0x0000009D -> TxD bits 0,1,0,1,1,1,0,0,1,P=1,1, each 16 clocks.
//     TxRDY=0 and TxBusy=1 for 176 clocks, then both return to idle values.
//  3. Loopback to uart_rcv, WR 0x99 -> receiver RxRDY=1, Dout[7:0]=0x99, RxParityErr=0
//     (P=0). Then WR 0x9D -> Dout[7:0]=0x9D, RxParityErr=0.
//  4. No FIFO: WR 0x55, then WR 0xAA at clock 40 -> 0xAA dropped.
//     Only one 176-clock frame carrying 0x55 (P=0).
//  5. Reset asserted at clock 60 of a 0xFF frame -> TxD=1 and TxRDY=1 next edge.
//     A following WR 0x01 produces a clean full frame.
//  6. FIFO_EN: WR 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> all accepted.
//     5 frames back-to-back, 880 clocks with no idle gap. A WR while TxRDY=0 is dropped.

Source files
------------

// File: rtl/uart_xmit.sv
// UART transmitter: start(0), D0..D7, even parity, stop(1); each bit CLKS_PER_BIT clocks.
// Define UART_XMIT_FIFO_EN to place a FIFO_DEPTH-entry transmit FIFO ahead of the serialiser.
module uart_xmit #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Din,
    input  logic        WR,
    output logic        TxD,
    output logic        TxRDY,
    output logic        TxBusy
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {s_idle, s_start, s_data, s_parity, s_stop} state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic          bit_end;
    logic          load;
    logic [7:0]    load_data;
    logic          unused_din;

    assign bit_end    = (clk_cnt == CLK_LAST);
    assign unused_din = ^Din[31:8];

`ifdef UART_XMIT_FIFO_EN
    localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = PW + 1;
    localparam logic [PW:0] FULL_CNT = CNTW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic [PW:0]   count_nxt;
    logic          push;

    assign push      = WR && TxRDY;
    // Pop at the stop-bit terminal count too, so queued frames leave with no idle gap.
    assign load      = (count != '0) && ((state == s_idle) || ((state == s_stop) && bit_end));
    assign load_data = mem[rptr];
    assign count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, load};

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wptr] <= Din[7:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            TxRDY <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (load) begin
                rptr <= rptr + PW'(1);
            end
            count <= count_nxt;
            TxRDY <= (count_nxt != FULL_CNT);
        end
    end
`else
    localparam int unsigned unused_depth = FIFO_DEPTH;

    assign load      = WR && TxRDY;
    assign load_data = Din[7:0];
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= s_idle;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
            TxD     <= 1'b1;
            TxBusy  <= 1'b0;
`ifndef UART_XMIT_FIFO_EN
            TxRDY   <= 1'b1;
`endif
        end else if (load) begin
            state   <= s_start;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= load_data;
            parity  <= ^load_data;
            TxD     <= 1'b0;
            TxBusy  <= 1'b1;
`ifndef UART_XMIT_FIFO_EN
            TxRDY   <= 1'b0;
`endif
        end else begin
            unique case (state)
                s_idle: begin
                    clk_cnt <= '0;
                end
                s_start: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        TxD     <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        state   <= s_data;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                s_data: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            TxD     <= parity;
                            state   <= s_parity;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            TxD     <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                s_parity: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        TxD     <= 1'b1;
                        state   <= s_stop;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                s_stop: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        TxBusy  <= 1'b0;
                        state   <= s_idle;
`ifndef UART_XMIT_FIFO_EN
                        TxRDY   <= 1'b1;
`endif
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= s_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_xmit.sv
// Bench for uart_xmit: expected bytes queue on each accepted write and are checked
// against frames decoded from TxD by mid-bit sampling.
module tb_uart_xmit;
    localparam int unsigned CPB   = 16;
    localparam int unsigned FRAME = 11 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr  = 1'b0;
    logic [31:0] din = '0;
    logic        txd;
    logic        txrdy;
    logic        txbusy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] exp_q[$];

    uart_xmit #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .Clock (clk),
        .Reset (rst),
        .Din   (din),
        .WR    (wr),
        .TxD   (txd),
        .TxRDY (txrdy),
        .TxBusy(txbusy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a write for 'hold' cycles; queue the byte when the bench expects acceptance.
    task automatic send(input logic [31:0] w, input int hold, input bit accept);
        din = w;
        wr  = 1'b1;
        if (accept) exp_q.push_back(w[7:0]);
        repeat (hold) @(negedge clk);
        wr = 1'b0;
    endtask

    // Decode one frame from TxD and compare it with the head of the scoreboard.
    task automatic check_frame(input string tag, output int start_cyc, output logic [10:0] bits);
        int n;
        logic first, stable, busy_ok, rdy_ok;
        logic [7:0] exp_b;
        n = 0;
        start_cyc = -1;
        bits = '0;
        while (txd !== 1'b0 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " start_seen"}, 32'(n < 4 * FRAME), 1);
        if (n >= 4 * FRAME) return;
        start_cyc = cyc;
        stable  = 1'b1;
        busy_ok = 1'b1;
        rdy_ok  = 1'b1;
        first   = 1'b0;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (c == 0) first = txd;
                else if (txd !== first) stable = 1'b0;
                if (c == CPB / 2) bits[b] = txd;
                if (txbusy !== 1'b1) busy_ok = 1'b0;
                if (txrdy !== 1'b0) rdy_ok = 1'b0;
                if (!(b == 10 && c == CPB - 1)) @(negedge clk);
            end
        end
        chk({tag, " bits_stable"}, stable, 1);
        chk({tag, " busy_held"}, busy_ok, 1);
`ifndef UART_XMIT_FIFO_EN
        chk({tag, " rdy_low"}, rdy_ok, 1);
`endif
        chk({tag, " start_bit"}, bits[0], 0);
        chk({tag, " stop_bit"}, bits[10], 1);
        chk({tag, " rx_parity_ok"}, bits[9], ^bits[8:1]);
        chk({tag, " sb_nonempty"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            chk({tag, " data"}, bits[8:1], exp_b);
            chk({tag, " parity"}, bits[9], ^exp_b);
        end
        @(negedge clk);
    endtask

    initial begin
        int s0;
        int s[5];
        int n;
        logic [10:0] fb;
        logic hi_ok;

        // Reset and idle line
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset txd", txd, 1);
        chk("reset txrdy", txrdy, 1);
        chk("reset txbusy", txbusy, 0);
        rst = 1'b0;
        hi_ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || txbusy !== 1'b0) hi_ok = 1'b0;
        end
        chk("idle_100 txd_high", hi_ok, 1);

        // Single frame 0x9D, exact line pattern
        send(32'h0000009D, 1, 1);
        check_frame("t2", s0, fb);
        chk("t2 pattern", fb, {1'b1, 1'b1, 8'h9D, 1'b0});
        chk("t2 idle txd", txd, 1);
        chk("t2 idle txbusy", txbusy, 0);
        chk("t2 idle txrdy", txrdy, 1);

        // Receiver-style decode of 0x99 (P=0) then 0x9D
        send(32'h5A3C2B99, 1, 1);
        check_frame("t3a", s0, fb);
        chk("t3a p0", fb[9], 0);
        send(32'hFFFFFF9D, 1, 1);
        check_frame("t3b", s0, fb);

`ifndef UART_XMIT_FIFO_EN
        // Held write takes one byte; write during frame is dropped
        fork
            send(32'h12345655, 3, 1);
            check_frame("t4", s0, fb);
            begin
                repeat (40) @(negedge clk);
                send(32'h000000AA, 1, 0);
            end
        join
        hi_ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || txbusy !== 1'b0) hi_ok = 1'b0;
        end
        chk("t4 no_second_frame", hi_ok, 1);
        chk("t4 sb_empty", exp_q.size(), 0);
`endif

        // Reset in the middle of a 0xFF frame, then a clean frame
        send(32'h000000FF, 1, 1);
        n = 0;
        while (txd !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5 start_seen", 32'(n < 50), 1);
        repeat (59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 abort txd", txd, 1);
        chk("t5 abort txrdy", txrdy, 1);
        chk("t5 abort txbusy", txbusy, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("t5 still idle", txd, 1);
        send(32'h00000001, 1, 1);
        check_frame("t5", s0, fb);
        chk("t5 pattern", fb, {1'b1, 1'b1, 8'h01, 1'b0});

`ifdef UART_XMIT_FIFO_EN
        // Five consecutive writes fill the FIFO; sixth is dropped; frames back-to-back
        fork
            begin
                send(32'h00000011, 1, 1);
                send(32'h00000022, 1, 1);
                send(32'h00000033, 1, 1);
                send(32'h00000044, 1, 1);
                send(32'h00000055, 1, 1);
                chk("t6 full txrdy", txrdy, 0);
                send(32'h00000066, 1, 0);
            end
            for (int i = 0; i < 5; i++) begin
                check_frame($sformatf("t6_%0d", i), s[i], fb);
            end
        join
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t6 gap_%0d", i), s[i] - s[i-1], FRAME);
        end
        chk("t6 total", s[4] - s[0] + FRAME, 5 * FRAME);
        chk("t6 idle txd", txd, 1);
        chk("t6 idle txbusy", txbusy, 0);
        chk("t6 sb_empty", exp_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
